// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker
// Measures the bit error rate of a decoder by aligning its output stream with
// the original payload. A shift history of reference bits is searched for the
// decoder latency k; once SYNC_LEN consecutive matches are seen at one k the
// checker locks and counts compared bits and errors. LOSS_RUN consecutive
// mismatches while locked drop back to searching at the next k.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   enable_i     run enable; low returns to IDLE
//   clear_i      synchronous clear of bit/err/relock counters
//   ref_bit_i    reference payload bit, qualified by ref_valid_i
//   dec_bit_i    decoded bit, qualified by dec_valid_i
//   locked_o     high while locked
//   latency_o    current candidate / locked latency k
//   bit_ct_o     bits compared while locked (saturating)
//   err_ct_o     mismatches counted while locked (saturating)
//   relock_ct_o  number of lock losses (saturating)
module viterbi_ber_checker #(
  parameter int unsigned MAX_LAT  = 64,
  parameter int unsigned SYNC_LEN = 16,
  parameter int unsigned LOSS_RUN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic                       ref_bit_i,
  input  logic                       ref_valid_i,
  input  logic                       dec_bit_i,
  input  logic                       dec_valid_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] latency_o,
  output logic [31:0]                bit_ct_o,
  output logic [31:0]                err_ct_o,
  output logic [15:0]                relock_ct_o
);

  localparam int unsigned KW = $clog2(MAX_LAT);
  localparam int unsigned MW = $clog2(SYNC_LEN + 1);
  localparam int unsigned LW = $clog2(LOSS_RUN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [MAX_LAT-1:0]   hist_q;
  logic [KW-1:0]        k_q, k_d;
  logic [MW-1:0]        match_run_q, match_run_d;
  logic [LW-1:0]        miss_run_q, miss_run_d;
  logic [31:0]          bit_ct_q, bit_ct_d;
  logic [31:0]          err_ct_q, err_ct_d;
  logic [15:0]          relock_ct_q, relock_ct_d;
  logic                 locked_q;

  logic                 cmp_c;
  logic                 mismatch_c;
  logic [KW-1:0]        k_next_c;
  logic [MW-1:0]        match_inc_c;
  logic [LW-1:0]        miss_inc_c;

  // Comparison qualifier: a same-cycle clear or a drop of enable discards it.
  assign cmp_c       = dec_valid_i && enable_i && !clear_i && (state_q != ST_IDLE);
  // History is read before this cycle's shift takes effect.
  assign mismatch_c  = dec_bit_i ^ hist_q[k_q];
  assign k_next_c    = (k_q == KW'(MAX_LAT - 1)) ? '0 : k_q + KW'(1);
  assign match_inc_c = match_run_q + MW'(1);
  assign miss_inc_c  = miss_run_q + LW'(1);

  // Reference history shifts on every valid reference bit, in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else if (ref_valid_i) begin
      hist_q <= {hist_q[MAX_LAT-2:0], ref_bit_i};
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      bit_ct_q    <= '0;
      err_ct_q    <= '0;
      relock_ct_q <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      bit_ct_q    <= bit_ct_d;
      err_ct_q    <= err_ct_d;
      relock_ct_q <= relock_ct_d;
      locked_q    <= (state_d == ST_LOCKED);
    end
  end

  // Next-state, latency search and saturating counters.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    bit_ct_d    = bit_ct_q;
    err_ct_d    = err_ct_q;
    relock_ct_d = relock_ct_q;

    if (!enable_i) begin
      state_d     = ST_IDLE;
      k_d         = '0;
      match_run_d = '0;
      miss_run_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_SEARCH;
          k_d         = '0;
          match_run_d = '0;
          miss_run_d  = '0;
        end
        ST_SEARCH: begin
          if (cmp_c) begin
            if (mismatch_c) begin
              match_run_d = '0;
              k_d         = k_next_c;
            end else if (match_inc_c == MW'(SYNC_LEN)) begin
              state_d     = ST_LOCKED;
              match_run_d = '0;
              miss_run_d  = '0;
            end else begin
              match_run_d = match_inc_c;
            end
          end
        end
        ST_LOCKED: begin
          if (cmp_c) begin
            if (bit_ct_q != '1) bit_ct_d = bit_ct_q + 32'd1;
            if (mismatch_c) begin
              if (err_ct_q != '1) err_ct_d = err_ct_q + 32'd1;
              if (miss_inc_c == LW'(LOSS_RUN)) begin
                state_d     = ST_SEARCH;
                k_d         = k_next_c;
                match_run_d = '0;
                miss_run_d  = '0;
                if (relock_ct_q != '1) relock_ct_d = relock_ct_q + 16'd1;
              end else begin
                miss_run_d = miss_inc_c;
              end
            end else begin
              miss_run_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Clear wins over any same-cycle count.
    if (clear_i) begin
      bit_ct_d    = '0;
      err_ct_d    = '0;
      relock_ct_d = '0;
    end
  end

  assign locked_o    = locked_q;
  assign latency_o   = k_q;
  assign bit_ct_o    = bit_ct_q;
  assign err_ct_o    = err_ct_q;
  assign relock_ct_o = relock_ct_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: a queue-based behavioural model tracks the
// expected outputs every cycle; literal checks pin the directed scenarios.
module tb_viterbi_ber_checker;

  localparam int unsigned MAX_LAT  = 64;
  localparam int unsigned SYNC_LEN = 16;
  localparam int unsigned LOSS_RUN = 8;
  localparam int unsigned KW       = $clog2(MAX_LAT);

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_LOCKED = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          ref_bit_i = 1'b0;
  logic          ref_valid_i = 1'b0;
  logic          dec_bit_i = 1'b0;
  logic          dec_valid_i = 1'b0;
  logic          locked_o;
  logic [KW-1:0] latency_o;
  logic [31:0]   bit_ct_o;
  logic [31:0]   err_ct_o;
  logic [15:0]   relock_ct_o;

  viterbi_ber_checker #(
    .MAX_LAT (MAX_LAT),
    .SYNC_LEN(SYNC_LEN),
    .LOSS_RUN(LOSS_RUN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable_i),
    .clear_i    (clear_i),
    .ref_bit_i  (ref_bit_i),
    .ref_valid_i(ref_valid_i),
    .dec_bit_i  (dec_bit_i),
    .dec_valid_i(dec_valid_i),
    .locked_o   (locked_o),
    .latency_o  (latency_o),
    .bit_ct_o   (bit_ct_o),
    .err_ct_o   (err_ct_o),
    .relock_ct_o(relock_ct_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_state = M_IDLE;
  int          m_k = 0;
  int          m_mr = 0;
  int          m_ms = 0;
  logic [31:0] m_bit = '0;
  logic [31:0] m_err = '0;
  logic [15:0] m_rel = '0;
  bit          mhist[$];
  logic        force_pending = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = M_IDLE; m_k = 0; m_mr = 0; m_ms = 0;
      m_bit = '0; m_err = '0; m_rel = '0;
      mhist.delete();
      for (int i = 0; i < MAX_LAT; i++) mhist.push_back(1'b0);
    end else begin
      bit cmp;
      bit mm;
      cmp = dec_valid_i && enable_i && !clear_i && (m_state != M_IDLE);
      mm  = (dec_bit_i != mhist[m_k]);
      if (!enable_i) begin
        m_state = M_IDLE; m_k = 0; m_mr = 0; m_ms = 0;
      end else if (m_state == M_IDLE) begin
        m_state = M_SEARCH;
      end else if (cmp && m_state == M_SEARCH) begin
        if (mm) begin
          m_mr = 0;
          m_k  = (m_k + 1) % MAX_LAT;
        end else begin
          m_mr++;
          if (m_mr == SYNC_LEN) begin m_state = M_LOCKED; m_mr = 0; m_ms = 0; end
        end
      end else if (cmp && m_state == M_LOCKED) begin
        if (m_bit != 32'hFFFF_FFFF) m_bit = m_bit + 32'd1;
        if (mm) begin
          if (m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
          m_ms++;
          if (m_ms == LOSS_RUN) begin
            m_state = M_SEARCH;
            m_k     = (m_k + 1) % MAX_LAT;
            m_mr    = 0;
            m_ms    = 0;
            if (m_rel != 16'hFFFF) m_rel = m_rel + 16'd1;
          end
        end else begin
          m_ms = 0;
        end
      end
      if (clear_i) begin m_bit = '0; m_err = '0; m_rel = '0; end
      if (force_pending) m_bit = 32'hFFFF_FFFE;
      if (ref_valid_i) begin
        mhist.push_front(ref_bit_i);
        void'(mhist.pop_back());
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic check_model();
    logic [KW-1:0] exp_k;
    logic          exp_lock;
    exp_k    = KW'(m_k);
    exp_lock = (m_state == M_LOCKED);
    n_chk++;
    if (locked_o !== exp_lock || latency_o !== exp_k || bit_ct_o !== m_bit ||
        err_ct_o !== m_err || relock_ct_o !== m_rel) begin
      n_fail++;
      $display("FAIL model t=%0t got lock=%b k=%0d bit=%0h err=%0h rel=%0h want lock=%b k=%0d bit=%0h err=%0h rel=%0h",
               $time, locked_o, latency_o, bit_ct_o, err_ct_o, relock_ct_o,
               exp_lock, exp_k, m_bit, m_err, m_rel);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  bit       genh[$];
  logic [6:0] p7 = 7'h7F;
  logic [8:0] p9 = 9'h1FF;
  bit       use9 = 1'b0;

  function automatic bit next_ref();
    bit nb;
    if (use9) begin
      nb = p9[8] ^ p9[4];
      p9 = {p9[7:0], nb};
    end else begin
      nb = p7[6] ^ p7[5];
      p7 = {p7[5:0], nb};
    end
    return nb;
  endfunction

  task automatic gen_reset();
    genh.delete();
    for (int i = 0; i < MAX_LAT; i++) genh.push_back(1'b0);
  endtask

  task automatic drive(input bit rv, input bit rb, input bit dv, input bit db);
    ref_valid_i = rv; ref_bit_i = rb; dec_valid_i = dv; dec_bit_i = db;
    @(negedge clk);
    check_model();
    if (rv) begin
      genh.push_front(rb);
      void'(genh.pop_back());
    end
  endtask

  task automatic push_ref_only();
    drive(1'b1, next_ref(), 1'b0, 1'b0);
  endtask

  task automatic step_delay(input int delay, input bit inv);
    bit db;
    db = genh[delay] ^ inv;
    drive(1'b1, next_ref(), 1'b1, db);
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    clear_i = 1'b0;
  endtask

  initial begin
    int p0, p1, p2;
    gen_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_lit("reset_locked", 32'(locked_o), 32'd0);
    check_lit("reset_latency", 32'(latency_o), 32'd0);
    check_lit("reset_bit_ct", bit_ct_o, 32'd0);
    check_lit("reset_err_ct", err_ct_o, 32'd0);
    check_lit("reset_relock", 32'(relock_ct_o), 32'd0);

    // Acquire at delay 5 on PRBS7, history prefilled while idle.
    repeat (70) push_ref_only();
    enable_i = 1'b1;
    for (int i = 0; i < 400 && !locked_o; i++) step_delay(5, 1'b0);
    check_lit("acq5_locked", 32'(locked_o), 32'd1);
    check_lit("acq5_latency", 32'(latency_o), 32'd5);
    check_lit("acq5_err_ct", err_ct_o, 32'd0);
    check_lit("acq5_bit_ct", bit_ct_o, 32'd0);

    // Three isolated errors within 100 compared bits.
    clear_pulse();
    p0 = 10 + $urandom_range(0, 20);
    p1 = 40 + $urandom_range(0, 20);
    p2 = 70 + $urandom_range(0, 20);
    for (int i = 0; i < 100; i++) step_delay(5, (i == p0) || (i == p1) || (i == p2));
    check_lit("iso_err_ct", err_ct_o, 32'd3);
    check_lit("iso_bit_ct", bit_ct_o, 32'd100);
    check_lit("iso_locked", 32'(locked_o), 32'd1);

    // Burst of LOSS_RUN errors forces loss and advances k.
    clear_pulse();
    repeat (8) step_delay(5, 1'b1);
    check_lit("loss_locked", 32'(locked_o), 32'd0);
    check_lit("loss_relock", 32'(relock_ct_o), 32'd1);
    check_lit("loss_latency", 32'(latency_o), 32'd6);
    check_lit("loss_err_ct", err_ct_o, 32'd8);
    check_lit("loss_bit_ct", bit_ct_o, 32'd8);
    for (int i = 0; i < 1000 && !locked_o; i++) step_delay(5, 1'b0);
    check_lit("wrap_locked", 32'(locked_o), 32'd1);
    check_lit("wrap_latency", 32'(latency_o), 32'd5);

    // Saturation of bit_ct near all-ones, then clear.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    force dut.bit_ct_q = 32'hFFFF_FFFE;
    force_pending = 1'b1;
    @(negedge clk);
    check_model();
    #1;
    release dut.bit_ct_q;
    force_pending = 1'b0;
    repeat (3) step_delay(5, 1'b0);
    check_lit("sat_bit_ct", bit_ct_o, 32'hFFFF_FFFF);
    clear_pulse();
    check_lit("clr_bit_ct", bit_ct_o, 32'd0);
    check_lit("clr_relock", 32'(relock_ct_o), 32'd0);
    check_lit("clr_locked", 32'(locked_o), 32'd1);

    // Asynchronous reset while locked.
    repeat (40) step_delay(5, 1'b0);
    check_lit("pre_rst_bit_ct", bit_ct_o, 32'd40);
    #2;
    rst = 1'b0;
    #1;
    check_lit("rst_locked", 32'(locked_o), 32'd0);
    check_lit("rst_latency", 32'(latency_o), 32'd0);
    check_lit("rst_bit_ct", bit_ct_o, 32'd0);
    check_lit("rst_err_ct", err_ct_o, 32'd0);
    check_lit("rst_relock", 32'(relock_ct_o), 32'd0);
    enable_i = 1'b0;
    @(negedge clk);
    check_model();
    gen_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_lit("post_rst_locked", 32'(locked_o), 32'd0);

    // Maximum delay, then shift to zero: loss and wrap 63 -> 0.
    use9 = 1'b1;
    repeat (70) push_ref_only();
    enable_i = 1'b1;
    for (int i = 0; i < 2000 && !locked_o; i++) step_delay(MAX_LAT - 1, 1'b0);
    check_lit("max_locked", 32'(locked_o), 32'd1);
    check_lit("max_latency", 32'(latency_o), 32'(MAX_LAT - 1));
    for (int i = 0; i < 3000 && locked_o; i++) step_delay(0, 1'b0);
    check_lit("zero_loss_locked", 32'(locked_o), 32'd0);
    check_lit("zero_loss_latency", 32'(latency_o), 32'd0);
    check_lit("zero_loss_relock", 32'(relock_ct_o), 32'd1);
    for (int i = 0; i < 200 && !locked_o; i++) step_delay(0, 1'b0);
    check_lit("zero_locked", 32'(locked_o), 32'd1);
    check_lit("zero_latency", 32'(latency_o), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit rv, dv, db;
      enable_i = ($urandom_range(0, 149) != 0);
      clear_i  = ($urandom_range(0, 299) == 0);
      rv = ($urandom_range(0, 3) != 0);
      dv = ($urandom_range(0, 9) == 0) ? ~rv : rv;
      db = ($urandom_range(0, 24) == 0) ? bit'($urandom_range(0, 1)) : genh[5];
      drive(rv, bit'($urandom_range(0, 1)), dv, db);
    end
    clear_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_checker.md
VITERBI_BER_CHECKER -- requirements
Module: viterbi_ber_checker

Parameters
REQ-001 SHALL have parameter MAX_LAT, default 64, meaning the history depth and the number of candidate decoder latencies (0..MAX_LAT-1).
REQ-002 SHALL have parameter SYNC_LEN, default 16, meaning the consecutive matches required to declare lock.
REQ-003 SHALL have parameter LOSS_RUN, default 8, meaning the consecutive mismatches that force loss of lock.

Interface
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 enable_i  input  1  checker run enable; low forces IDLE.
REQ-007 clear_i  input  1  synchronous clear of bit/err/relock counters.
REQ-008 ref_bit_i  input  1  original payload bit (encoder input side).
REQ-009 ref_valid_i  input  1  qualifies ref_bit_i.
REQ-010 dec_bit_i  input  1  decoded bit from decoder.
REQ-011 dec_valid_i  input  1  qualifies dec_bit_i.
REQ-012 locked_o  output  1  high in LOCKED state.
REQ-013 latency_o  output  $clog2(MAX_LAT)  current candidate/locked delay k.
REQ-014 bit_ct_o  output  32  decoded bits compared while LOCKED.
REQ-015 err_ct_o  output  32  mismatches counted while LOCKED.
REQ-016 relock_ct_o  output  16  number of LOCKED->SEARCH transitions.

Function
REQ-017 History h[0..MAX_LAT-1] SHALL shift on each ref_valid_i cycle (h[0]<=ref_bit_i, h[i]<=h[i-1]) in every state, including IDLE.
REQ-018 A comparison SHALL occur on each dec_valid_i cycle outside IDLE: mismatch = dec_bit_i XOR h[k], using h as registered before any same-cycle shift.
REQ-019 States SHALL be IDLE, SEARCH, LOCKED; encoding is implementation choice.
REQ-020 IDLE: k=0, run counters 0; enable_i high -> SEARCH next cycle.
REQ-021 SEARCH: match increments match_run; match_run reaching SYNC_LEN -> LOCKED, k held.
REQ-022 SEARCH mismatch: match_run<=0, k<=k+1, wrapping MAX_LAT-1 -> 0.
REQ-023 LOCKED: each comparison increments bit_ct; mismatch also increments err_ct and miss_run; match clears miss_run.
REQ-024 LOCKED: miss_run reaching LOSS_RUN -> SEARCH with k<=k+1 (wrapping), match_run<=0, relock_ct+1; bit_ct/err_ct retain value.
REQ-025 enable_i low in any state -> IDLE next cycle; counters hold their values.
REQ-026 bit_ct, err_ct, relock_ct SHALL saturate at all-ones, never wrap.
REQ-027 clear_i zeroes bit_ct, err_ct, relock_ct; same-cycle comparison is discarded (clear wins); FSM state unaffected.
REQ-028 All outputs SHALL be registered; counter outputs reflect a comparison one cycle after its dec_valid_i cycle.
REQ-029 dec_valid_i with no preceding ref_valid_i compares against reset history (all 0); no special handling.

Reset
REQ-030 rst low SHALL asynchronously force IDLE, h all 0, k=0, match_run=0, miss_run=0, and locked_o=0, latency_o=0, bit_ct_o=0, err_ct_o=0, relock_ct_o=0.
REQ-031 rst asserted mid-LOCKED SHALL discard all counts; after release, operation restarts from IDLE.

Verification
REQ-032 Ref=PRBS7, dec = ref delayed by 5 valids, enable high -> locked_o high after 5 mismatches + 16 matches, latency_o=5, err_ct_o=0.
REQ-033 Locked at k=5, invert 3 isolated dec bits within 100 compared bits -> err_ct_o=3, bit_ct_o=100, locked_o stays high.
REQ-034 Locked at k=5, invert 8 consecutive dec bits -> locked_o low, relock_ct_o=1, latency_o=6, err_ct_o=8; later search wraps to re-acquire k=5.
REQ-035 Dec delay 63 (MAX_LAT-1) -> lock at latency_o=63; delay shifted to 0 after lock -> loss, then k wraps 63->0 and relocks at 0.
REQ-036 Force bit_ct to 32'hFFFF_FFFE, compare 3 bits -> bit_ct_o=32'hFFFF_FFFF; clear_i pulse -> 0 next cycle.
REQ-037 rst pulse while LOCKED with bit_ct_o=40 -> all outputs 0 immediately, locked_o=0, state IDLE.
